// File: rtl/lsp_cb_search.sv
// Nearest-entry search over one LSP codebook, one entry per clock via the cbselect mux.
// Returns index, value and 33-bit absolute error of the closest entry; ties keep the lower index.
module lsp_cb_search #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [3:0]   i_cb_num,
  input  logic [N-1:0] i_target,
  output logic [3:0]   o_cb_select,
  output logic [3:0]   o_cb_addr,
  input  logic [N-1:0] i_cb_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [3:0]   o_best_index,
  output logic [N-1:0] o_best_value,
  output logic [N:0]   o_best_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  function automatic logic [3:0] f_clamp(input logic [3:0] cb);
    f_clamp = (cb > 4'd9) ? 4'd9 : cb;
  endfunction

  function automatic logic [3:0] f_last_addr(input logic [3:0] sel);
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: f_last_addr = 4'd15;
      4'd7, 4'd8:                               f_last_addr = 4'd7;
      default:                                  f_last_addr = 4'd3;
    endcase
  endfunction

  state_t       r_state;
  logic [3:0]   r_cb_select;
  logic [3:0]   r_cb_addr;
  logic [N-1:0] r_target;
  logic         r_busy;
  logic         r_done;
  logic [3:0]   r_best_index;
  logic [N-1:0] r_best_value;
  logic [N:0]   r_best_err;

  state_t       w_state_nxt;
  logic [3:0]   w_cb_select_nxt;
  logic [3:0]   w_cb_addr_nxt;
  logic [N-1:0] w_target_nxt;
  logic         w_busy_nxt;
  logic         w_done_nxt;
  logic [3:0]   w_best_index_nxt;
  logic [N-1:0] w_best_value_nxt;
  logic [N:0]   w_best_err_nxt;
  logic [N:0]   w_diff;
  logic [N:0]   w_err;

  // N+1 bits hold |(-2^(N-1)) - (2^(N-1)-1)| without overflow.
  assign w_diff = {r_target[N-1], r_target} - {i_cb_data[N-1], i_cb_data};
  assign w_err  = w_diff[N] ? (~w_diff + ONE) : w_diff;

  // Next-state and next-register values for the search sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_cb_select_nxt  = r_cb_select;
    w_cb_addr_nxt    = r_cb_addr;
    w_target_nxt     = r_target;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_best_index_nxt = r_best_index;
    w_best_value_nxt = r_best_value;
    w_best_err_nxt   = r_best_err;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_cb_select_nxt = f_clamp(i_cb_num);
          w_target_nxt    = i_target;
          w_cb_addr_nxt   = 4'd0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_SCAN;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if ((r_cb_addr == 4'd0) || (w_err < r_best_err)) begin
          w_best_index_nxt = r_cb_addr;
          w_best_value_nxt = i_cb_data;
          w_best_err_nxt   = w_err;
        end else begin
          w_best_index_nxt = r_best_index;
        end
        if (r_cb_addr == f_last_addr(r_cb_select)) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cb_addr_nxt = r_cb_addr + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cb_select  <= 4'd0;
      r_cb_addr    <= 4'd0;
      r_target     <= {N{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_best_index <= 4'd0;
      r_best_value <= {N{1'b0}};
      r_best_err   <= {(N+1){1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_cb_select  <= w_cb_select_nxt;
      r_cb_addr    <= w_cb_addr_nxt;
      r_target     <= w_target_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_best_index <= w_best_index_nxt;
      r_best_value <= w_best_value_nxt;
      r_best_err   <= w_best_err_nxt;
    end
  end

  assign o_cb_select  = r_cb_select;
  assign o_cb_addr    = r_cb_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_best_index = r_best_index;
  assign o_best_value = r_best_value;
  assign o_best_err   = r_best_err;

endmodule

// File: doc/lsp_cb_search.md
# lsp_cb_search

Sequencer for the LSP scalar quantiser: on each request it walks one codebook (cb0–cb9) through the `cbselect` mux, one entry per clock. It compares every entry against a fixed-point target and returns the index, value and absolute error of the nearest entry. It sits inside `quantise`, between the LSP frame controller (the requester) and `cbselect` (the resource it drives).

## Interface
- `N`, default 32: data width, two's-complement Q15.16 (1 sign, 15 integer, 16 fraction bits).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request pulse; sampled only when `busy`=0.
- `cb_num` in 4: codebook to search, 0–9.
- `target` in N: value to quantise, Q15.16 signed.
- `cb_select` out 4: drives `cbselect.select`.
- `cb_addr` out 4: drives `cbselect.addr`.
- `cb_data` in N: `cbselect.dataout`, combinational from `cb_select`/`cb_addr` in the same cycle.
- `busy` out 1: high while a search is in progress.
- `done` out 1: one-cycle pulse when results are valid.
- `best_index` out 4: index of the nearest entry.
- `best_value` out N: codebook value at `best_index`.
- `best_err` out N+1: unsigned absolute error |target − best_value|.

## Operation
- States: IDLE, SCAN, DONE.
- Entry count M is set by the latched codebook number: cb0–cb6 → 16, cb7–cb8 → 8, cb9 → 4. `cb_num` > 9 is treated as 9 (M=4, `cb_select`=9).
- IDLE, `start`=1: latch `cb_num` (clamped) into `cb_select` and latch `target`. Set `cb_addr`=0, `busy`=1, go to SCAN.
- IDLE, `start`=0: hold all outputs.
- SCAN, every cycle:
  - diff = sign-extended target − sign-extended `cb_data`, computed in N+1 bits; err = |diff|, N+1 bits unsigned, no saturation.
  - If `cb_addr`=0 or err < stored error, load `best_index`←`cb_addr`, `best_value`←`cb_data`, `best_err`←err.
  - Ties keep the lower index (strict less-than).
  - If `cb_addr`=M−1, go to DONE; otherwise increment `cb_addr`.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE. A `start` seen in DONE is accepted as in IDLE, giving back-to-back searches.
- `start` while in SCAN is ignored. `target` and `cb_num` changes during SCAN have no effect.
- `best_*` is written only during SCAN and holds between searches. It may change on every SCAN cycle, so it is valid only from `done` until the next `start` is accepted.
- `cb_select` and `cb_addr` hold their last values in IDLE/DONE. `cb_addr` never exceeds M−1.

## Timing
- Reset (async, immediate): state IDLE. `cb_select`=0, `cb_addr`=0, `busy`=0, `done`=0, `best_index`=0, `best_value`=0, `best_err`=0.
- Reset during SCAN aborts the search with no `done` pulse. The first `start` after reset deasserts is serviced normally.
- `busy` rises on the edge that samples `start` and falls on the edge that enters DONE.
- Latency: `done` is high in the cycle following the M-th rising edge after the `start` sampling edge; the search occupies M SCAN cycles. That is 16 for cb0–cb6, 8 for cb7–cb8, 4 for cb9.
- Minimum repeat interval: M+1 cycles, with `start` held or re-pulsed during DONE.
- `cb_data` must settle within the same cycle: the path `cb_addr` → ROM → `cbselect` → subtract/compare → register is one cycle and must meet the clock.

## Test plan
- **cb0 nearest match:** ROM cb0 entry 5 = 0x00010000 (1.0); `cb_num`=0, `target`=0x00010800. Expect `done` 16 cycles after start, `best_index`=5, `best_err`=0x000000800, `busy` high for exactly 16 cycles.
- **Short codebook with out-of-range select:** `cb_num`=12, `target`=0. Expect `cb_select`=9 and `cb_addr` sweeping 0..3 only, with `done` 4 cycles after start. `best_index` is the cb9 entry with minimum |value|, lowest index on a tie.
- **Tie and negative/extreme handling:** codebook model whose entries 2 and 7 are equidistant from `target`=0xFFFF8000 (−0.5), one on each side. Expect `best_index`=2. Also `target`=0x80000000 against entry 0x7FFFFFFF: `best_err`=0x0FFFFFFFF, so the 33-bit width has no overflow.
- **Ignored start and back-to-back:** pulse `start` mid-SCAN with a different `cb_num`; expect no restart and the original results. Assert `start` during DONE with `cb_num`=7; expect an 8-cycle search to follow immediately and `done` 8 cycles later.
- **Async reset mid-SCAN:** assert `rst` at `cb_addr`=6 between clock edges. Expect all outputs 0 immediately, with no `done` pulse. After `rst` deasserts, a new `cb_num`=3 search completes in 16 cycles with correct results.
